// File: rtl/sipo_frame.sv
// sipo_frame: serial-in/parallel-out deserialiser with a held output word.
//   Bits from `inp` are shifted in on cycles where `enb` is high. Every WIDTH
//   bits form one frame. The completed frame is copied to `out` and
//   `out_valid` is raised. The consumer takes the word with `out_ready`.
//   A frame that completes while an unconsumed word is still held is
//   dropped, and the sticky `overrun` flag is set.
// Parameters:
//   WIDTH      frame width in bits (>= 2)
//   MSB_FIRST  1: shift left, new bit enters bit 0
//              0: shift right, new bit enters bit WIDTH-1
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   enb, inp      shift enable and serial data bit
//   sync          discard the partial frame (realign)
//   shift_out     live shift register contents
//   out           last accepted complete word, held
//   out_valid     out holds an unconsumed word
//   out_ready     consumer accepts out this cycle
//   overrun       sticky: a completed word was dropped
//   clr_ovr       clears overrun (a simultaneous drop wins)
module sipo_frame #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enb,
  input  logic             inp,
  input  logic             sync,
  output logic [WIDTH-1:0] shift_out,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  input  logic             clr_ovr
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] sr, sr_nxt;
  logic [WIDTH-1:0] shifted, seeded;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] out_nxt;
  logic             valid_nxt, ovr_nxt;
  logic             frame_done, xfer;

  // Normal shift, and the first bit of a freshly realigned frame.
  generate
    if (MSB_FIRST) begin : g_msb
      assign shifted = {sr[WIDTH-2:0], inp};
      assign seeded  = {{(WIDTH-1){1'b0}}, inp};
    end else begin : g_lsb
      assign shifted = {inp, sr[WIDTH-1:1]};
      assign seeded  = {inp, {(WIDTH-1){1'b0}}};
    end
  endgenerate

  assign xfer = out_valid & out_ready;

  always_comb begin
    sr_nxt     = sr;
    cnt_nxt    = cnt;
    frame_done = 1'b0;
    if (sync) begin
      sr_nxt  = enb ? seeded : '0;
      cnt_nxt = enb ? CNT_W'(1) : '0;
    end else if (enb) begin
      sr_nxt     = shifted;
      frame_done = (cnt == LAST);
      cnt_nxt    = frame_done ? '0 : cnt + CNT_W'(1);
    end
  end

  // A transfer on the completing edge frees the holding register in time
  // for the new word, so back-to-back frames never drop.
  always_comb begin
    out_nxt   = out;
    valid_nxt = out_valid;
    ovr_nxt   = overrun & ~clr_ovr;
    if (frame_done) begin
      if (!out_valid || xfer) begin
        out_nxt   = shifted;
        valid_nxt = 1'b1;
      end else begin
        ovr_nxt = 1'b1;
      end
    end else if (xfer) begin
      valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr        <= '0;
      cnt       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      sr        <= sr_nxt;
      cnt       <= cnt_nxt;
      out       <= out_nxt;
      out_valid <= valid_nxt;
      overrun   <= ovr_nxt;
    end
  end

  assign shift_out = sr;

endmodule

// File: tb/tb_sipo_frame.sv
// tb_sipo_frame: directed bench for sipo_frame. Two WIDTH=4 instances share
// one stimulus: dut_m (MSB_FIRST=1) and dut_l (MSB_FIRST=0).
module tb_sipo_frame;

  logic       clk = 1'b0;
  logic       rst, enb, inp, sync, out_ready, clr_ovr;
  logic [3:0] m_shift, m_out, l_shift, l_out;
  logic       m_valid, m_ovr, l_valid, l_ovr;

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  sipo_frame #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .enb(enb), .inp(inp), .sync(sync),
    .shift_out(m_shift), .out(m_out), .out_valid(m_valid),
    .out_ready(out_ready), .overrun(m_ovr), .clr_ovr(clr_ovr)
  );

  sipo_frame #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .enb(enb), .inp(inp), .sync(sync),
    .shift_out(l_shift), .out(l_out), .out_valid(l_valid),
    .out_ready(out_ready), .overrun(l_ovr), .clr_ovr(clr_ovr)
  );

  // One rising edge; outputs are sampled and inputs changed 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bit_in(input logic b);
    enb = 1'b1;
    inp = b;
    tick();
    enb = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; enb = 1'b0; inp = 1'b0; sync = 1'b0; clr_ovr = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enb = 1'b1; inp = 1'b1; sync = 1'b0; clr_ovr = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0; enb = 1'b0;
    tests++;
    if ({m_shift, m_out, m_valid, m_ovr} !== 10'h0) begin
      fails++;
      $display("FAIL reset_m: got shift=%h out=%h v=%b o=%b expected all 0", m_shift, m_out, m_valid, m_ovr);
    end
    tests++;
    if ({l_shift, l_out, l_valid, l_ovr} !== 10'h0) begin
      fails++;
      $display("FAIL reset_l: got shift=%h out=%h v=%b o=%b expected all 0", l_shift, l_out, l_valid, l_ovr);
    end
    bit_in(1'b1); bit_in(1'b1); bit_in(1'b1);
    tests++;
    if (m_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_cnt_3bits: got valid=%b expected 0", m_valid);
    end
    bit_in(1'b1);
    tests++;
    if (m_valid !== 1'b1 || m_out !== 4'hF) begin
      fails++;
      $display("FAIL reset_cnt_4bits: got valid=%b out=%h expected 1 f", m_valid, m_out);
    end
  endtask

  task automatic test_msb_first();
    do_reset();
    out_ready = 1'b1;
    bit_in(1'b1); bit_in(1'b0);
    tests++;
    if (m_shift !== 4'b0010) begin
      fails++;
      $display("FAIL msb_shift_2: got %b expected 0010", m_shift);
    end
    bit_in(1'b1); bit_in(1'b1);
    tests++;
    if (m_out !== 4'b1011 || m_valid !== 1'b1) begin
      fails++;
      $display("FAIL msb_word: got out=%b v=%b expected 1011 1", m_out, m_valid);
    end
    tick();
    tests++;
    if (m_valid !== 1'b0 || m_out !== 4'b1011) begin
      fails++;
      $display("FAIL msb_valid_1cyc: got v=%b out=%b expected 0 1011", m_valid, m_out);
    end
  endtask

  task automatic test_lsb_first();
    do_reset();
    out_ready = 1'b1;
    bit_in(1'b1); bit_in(1'b0);
    tick(); tick(); tick();
    tests++;
    if (l_valid !== 1'b0 || l_shift !== 4'b0100) begin
      fails++;
      $display("FAIL lsb_gap: got v=%b shift=%b expected 0 0100", l_valid, l_shift);
    end
    bit_in(1'b1); bit_in(1'b1);
    tests++;
    if (l_out !== 4'b1101 || l_valid !== 1'b1) begin
      fails++;
      $display("FAIL lsb_word: got out=%b v=%b expected 1101 1", l_out, l_valid);
    end
    tick();
    tests++;
    if (l_valid !== 1'b0) begin
      fails++;
      $display("FAIL lsb_no_extra_valid: got v=%b expected 0", l_valid);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    bit_in(1'b1); bit_in(1'b0); bit_in(1'b1); bit_in(1'b0);
    tests++;
    if (m_out !== 4'hA || m_valid !== 1'b1 || m_ovr !== 1'b0) begin
      fails++;
      $display("FAIL bp_first: got out=%h v=%b o=%b expected a 1 0", m_out, m_valid, m_ovr);
    end
    bit_in(1'b0); bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
    tests++;
    if (m_out !== 4'hA || m_valid !== 1'b1 || m_ovr !== 1'b1) begin
      fails++;
      $display("FAIL bp_drop: got out=%h v=%b o=%b expected a 1 1", m_out, m_valid, m_ovr);
    end
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    tests++;
    if (m_ovr !== 1'b0) begin
      fails++;
      $display("FAIL bp_clear: got o=%b expected 0", m_ovr);
    end
    bit_in(1'b1); bit_in(1'b1); bit_in(1'b1);
    clr_ovr = 1'b1;
    bit_in(1'b1);
    clr_ovr = 1'b0;
    tests++;
    if (m_ovr !== 1'b1 || m_out !== 4'hA) begin
      fails++;
      $display("FAIL bp_set_wins: got o=%b out=%h expected 1 a", m_ovr, m_out);
    end
  endtask

  task automatic test_sync();
    do_reset();
    out_ready = 1'b1;
    bit_in(1'b1); bit_in(1'b1);
    sync = 1'b1;
    bit_in(1'b1);
    sync = 1'b0;
    tests++;
    if (m_shift !== 4'b0001 || l_shift !== 4'b1000 || m_valid !== 1'b0) begin
      fails++;
      $display("FAIL sync_seed: got m=%b l=%b v=%b expected 0001 1000 0", m_shift, l_shift, m_valid);
    end
    bit_in(1'b0); bit_in(1'b1);
    tests++;
    if (m_valid !== 1'b0) begin
      fails++;
      $display("FAIL sync_no_partial_word: got v=%b expected 0", m_valid);
    end
    bit_in(1'b0);
    tests++;
    if (m_out !== 4'b1010 || m_valid !== 1'b1) begin
      fails++;
      $display("FAIL sync_word: got out=%b v=%b expected 1010 1", m_out, m_valid);
    end
    bit_in(1'b1);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    tests++;
    if (m_shift !== 4'b0000) begin
      fails++;
      $display("FAIL sync_idle_clear: got %b expected 0000", m_shift);
    end
  endtask

  task automatic test_concurrency();
    do_reset();
    out_ready = 1'b0;
    bit_in(1'b1); bit_in(1'b1); bit_in(1'b0); bit_in(1'b0);
    bit_in(1'b0); bit_in(1'b1); bit_in(1'b1);
    tests++;
    if (m_out !== 4'hC || m_valid !== 1'b1) begin
      fails++;
      $display("FAIL conc_hold: got out=%h v=%b expected c 1", m_out, m_valid);
    end
    out_ready = 1'b1;
    bit_in(1'b0);
    out_ready = 1'b0;
    tests++;
    if (m_out !== 4'h6 || m_valid !== 1'b1 || m_ovr !== 1'b0) begin
      fails++;
      $display("FAIL conc_xfer_and_done: got out=%h v=%b o=%b expected 6 1 0", m_out, m_valid, m_ovr);
    end
    bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if (m_out !== 4'h0 || m_valid !== 1'b0 || m_shift !== 4'h0) begin
      fails++;
      $display("FAIL conc_mid_reset: got out=%h v=%b shift=%h expected 0 0 0", m_out, m_valid, m_shift);
    end
    bit_in(1'b0); bit_in(1'b1); bit_in(1'b1); bit_in(1'b1);
    tests++;
    if (m_out !== 4'h7 || m_valid !== 1'b1) begin
      fails++;
      $display("FAIL conc_after_reset: got out=%h v=%b expected 7 1", m_out, m_valid);
    end
  endtask

  initial begin
    rst = 1'b1; enb = 1'b0; inp = 1'b0; sync = 1'b0; out_ready = 1'b0; clr_ovr = 1'b0;
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_backpressure();
    test_sync();
    test_concurrency();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
